// File: rtl/store_buffer_ctrl.sv
// Posted-store buffer: lane-aligns SB/SH/SW, queues DEPTH entries, drains over MemReq/MemAck.
// Optional load-hazard compare when STORE_BUF_FWD_EN is defined.
//
// state | meaning
// IDLE  | no request outstanding; load head entry when count > 0
// REQ   | MemReq held with head entry until MemAck
module store_buffer_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    StoreValidM,
  input  logic [1:0]              StoreSrcM,
  input  logic [ADDR_WIDTH-1:0]   AddrM,
  input  logic [DATA_WIDTH-1:0]   WriteDataM,
  output logic                    StoreReadyM,
  output logic                    StoreFaultM,
  output logic                    MemReq,
  output logic [ADDR_WIDTH-1:0]   MemAddr,
  output logic [DATA_WIDTH-1:0]   MemWData,
  output logic [DATA_WIDTH/8-1:0] MemByteEn,
  input  logic                    MemAck,
  output logic                    BufEmpty
`ifdef STORE_BUF_FWD_EN
  ,
  input  logic                    LoadValidM,
  input  logic [ADDR_WIDTH-1:0]   LoadAddrM,
  output logic                    LoadHazardM
`endif
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int BEW = DATA_WIDTH / 8;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           next_ptr;
  logic                    mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BEW-1:0]          mem_be_q, mem_be_d;
  logic                    fault_q, fault_d;

  logic [ADDR_WIDTH-1:0]   ent_addr_q [DEPTH];
  logic [DATA_WIDTH-1:0]   ent_data_q [DEPTH];
  logic [BEW-1:0]          ent_be_q   [DEPTH];

  logic [1:0]              lo;
  logic                    legal;
  logic                    push;
  logic                    pop;
  logic [ADDR_WIDTH-1:0]   new_addr;
  logic [DATA_WIDTH-1:0]   new_data;
  logic [BEW-1:0]          new_be;

  always_comb begin
    lo       = AddrM[1:0];
    legal    = 1'b0;
    new_data = WriteDataM;
    new_be   = '0;
    new_addr = {AddrM[ADDR_WIDTH-1:2], 2'b00};
    case (StoreSrcM)
      2'b00: begin
        legal    = (lo == 2'b00);
        new_be   = 4'b1111;
      end
      2'b01: begin
        legal    = 1'b1;
        new_data = {4{WriteDataM[7:0]}};
        new_be   = 4'b0001 << lo;
      end
      2'b10: begin
        legal    = ~lo[0];
        new_data = {2{WriteDataM[15:0]}};
        new_be   = lo[1] ? 4'b1100 : 4'b0011;
      end
      default: legal = 1'b0;
    endcase
  end

  // Readiness comes from the registered count only; a same-cycle pop never frees a slot.
  assign StoreReadyM = (count_q != CW'(DEPTH));
  assign push        = StoreValidM & StoreReadyM & legal;
  assign pop         = (state_q == REQ) & MemAck;
  assign next_ptr    = rd_ptr_q + PW'(1);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fault_d  = StoreValidM & ~legal;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = next_ptr;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_addr_d  = ent_addr_q[rd_ptr_q];
          mem_wdata_d = ent_data_q[rd_ptr_q];
          mem_be_d    = ent_be_q[rd_ptr_q];
        end
      end
      REQ: begin
        if (MemAck) begin
          // Chain straight into the next head so consecutive stores drain without a bubble.
          if (count_q > CW'(1)) begin
            mem_addr_d  = ent_addr_q[next_ptr];
            mem_wdata_d = ent_data_q[next_ptr];
            mem_be_d    = ent_be_q[next_ptr];
          end else begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_be_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      fault_q     <= fault_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
        ent_be_q[i]   <= '0;
      end
    end else if (push) begin
      ent_addr_q[wr_ptr_q] <= new_addr;
      ent_data_q[wr_ptr_q] <= new_data;
      ent_be_q[wr_ptr_q]   <= new_be;
    end
  end

  assign StoreFaultM = fault_q;
  assign MemReq      = mem_req_q;
  assign MemAddr     = mem_addr_q;
  assign MemWData    = mem_wdata_q;
  assign MemByteEn   = mem_be_q;
  assign BufEmpty    = (count_q == '0) & ~mem_req_q;

`ifdef STORE_BUF_FWD_EN
  logic [ADDR_WIDTH-1:0] load_word;
  logic [PW-1:0]         hz_idx;
  logic                  load_hit;

  assign load_word = LoadAddrM & ~ADDR_WIDTH'(3);

  always_comb begin
    load_hit = 1'b0;
    hz_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hz_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (ent_addr_q[hz_idx] == load_word)) load_hit = 1'b1;
    end
    if (mem_req_q && (mem_addr_q == load_word)) load_hit = 1'b1;
  end

  assign LoadHazardM = LoadValidM & load_hit;
`endif

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Bench for store_buffer_ctrl: queue-based reference model checked every cycle, plus directed literals.
module tb_store_buffer_ctrl;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          StoreValidM = 1'b0;
  logic [1:0]    StoreSrcM = 2'b00;
  logic [AW-1:0] AddrM = '0;
  logic [DW-1:0] WriteDataM = '0;
  logic          StoreReadyM;
  logic          StoreFaultM;
  logic          MemReq;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic [3:0]    MemByteEn;
  logic          MemAck = 1'b0;
  logic          BufEmpty;
`ifdef STORE_BUF_FWD_EN
  logic          LoadValidM = 1'b0;
  logic [AW-1:0] LoadAddrM = '0;
  logic          LoadHazardM;
`endif

  store_buffer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .StoreValidM(StoreValidM), .StoreSrcM(StoreSrcM), .AddrM(AddrM), .WriteDataM(WriteDataM),
    .StoreReadyM(StoreReadyM), .StoreFaultM(StoreFaultM),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemWData(MemWData), .MemByteEn(MemByteEn),
    .MemAck(MemAck), .BufEmpty(BufEmpty)
`ifdef STORE_BUF_FWD_EN
    , .LoadValidM(LoadValidM), .LoadAddrM(LoadAddrM), .LoadHazardM(LoadHazardM)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t mq[$];
  bit   req_m;
  bit   fault_m;
  int   sz0;
  bit   req0;
  int   checks;
  int   failures;
  int   accepted;
  int   drained;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_f(input logic [1:0] src, input logic [31:0] a);
    int lo;
    lo = int'(a % 4);
    if (src == 2'b00) return lo == 0;
    if (src == 2'b01) return 1'b1;
    if (src == 2'b10) return (lo % 2) == 0;
    return 1'b0;
  endfunction

  function automatic ent_t lane_f(input logic [1:0] src, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    int   lo;
    lo     = int'(a % 4);
    e.addr = a - 32'(lo);
    if (src == 2'b01) begin
      e.data = (d & 32'hFF) * 32'h01010101;
      e.be   = 4'(1 << lo);
    end else if (src == 2'b10) begin
      e.data = (d & 32'hFFFF) * 32'h00010001;
      e.be   = (lo >= 2) ? 4'hC : 4'h3;
    end else begin
      e.data = d;
      e.be   = 4'hF;
    end
    return e;
  endfunction

  // Reference model: queue holds every accepted store until its ack, head included.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      req_m   = 1'b0;
      fault_m = 1'b0;
    end else begin
      sz0  = mq.size();
      req0 = req_m;
      if (req0 && MemAck) begin
        void'(mq.pop_front());
        drained++;
        req_m = (sz0 > 1);
      end else if (!req0) begin
        req_m = (sz0 > 0);
      end
      fault_m = StoreValidM && !legal_f(StoreSrcM, AddrM);
      if (StoreValidM && legal_f(StoreSrcM, AddrM) && sz0 != DEPTH) begin
        mq.push_back(lane_f(StoreSrcM, AddrM, WriteDataM));
        accepted++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready", 32'(StoreReadyM), 32'(mq.size() != DEPTH));
      chk("buf_empty", 32'(BufEmpty), 32'(mq.size() == 0));
      chk("fault", 32'(StoreFaultM), 32'(fault_m));
      chk("mem_req", 32'(MemReq), 32'(req_m));
      if (req_m && mq.size() > 0) begin
        chk("mem_addr", MemAddr, mq[0].addr);
        chk("mem_wdata", MemWData, mq[0].data);
        chk("mem_be", 32'(MemByteEn), 32'(mq[0].be));
      end
    end
  end

  task automatic set_store(input logic [1:0] src, input logic [31:0] a, input logic [31:0] d);
    StoreValidM = 1'b1;
    StoreSrcM   = src;
    AddrM       = a;
    WriteDataM  = d;
  endtask

  logic [1:0]  bad_src [3];
  logic [31:0] bad_addr[3];

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bad_src[0] = 2'b00; bad_addr[0] = 32'h3001;
    bad_src[1] = 2'b10; bad_addr[1] = 32'h3003;
    bad_src[2] = 2'b11; bad_addr[2] = 32'h3000;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req", 32'(MemReq), 32'h0);
    chk("rst_addr", MemAddr, 32'h0);
    chk("rst_be", 32'(MemByteEn), 32'h0);
    chk("rst_ready", 32'(StoreReadyM), 32'h1);
    chk("rst_empty", 32'(BufEmpty), 32'h1);
    chk("rst_fault", 32'(StoreFaultM), 32'h0);

    // single SB into empty buffer
    MemAck = 1'b1;
    set_store(2'b01, 32'h1003, 32'h000000A5);
    @(negedge clk);
    StoreValidM = 1'b0;
    chk("t1_req_early", 32'(MemReq), 32'h0);
    @(negedge clk);
    chk("t1_req", 32'(MemReq), 32'h1);
    chk("t1_addr", MemAddr, 32'h1000);
    chk("t1_wdata", MemWData, 32'hA5A5A5A5);
    chk("t1_be", 32'(MemByteEn), 32'h8);
    @(negedge clk);
    chk("t1_req_done", 32'(MemReq), 32'h0);
    chk("t1_empty", 32'(BufEmpty), 32'h1);

    // SH then SW, back to back
    set_store(2'b10, 32'h2002, 32'h1234BEEF);
    @(negedge clk);
    set_store(2'b00, 32'h2000, 32'hCAFEF00D);
    @(negedge clk);
    StoreValidM = 1'b0;
    chk("t2_sh_wdata", MemWData, 32'hBEEFBEEF);
    chk("t2_sh_be", 32'(MemByteEn), 32'hC);
    @(negedge clk);
    chk("t2_sw_req", 32'(MemReq), 32'h1);
    chk("t2_sw_wdata", MemWData, 32'hCAFEF00D);
    chk("t2_sw_be", 32'(MemByteEn), 32'hF);
    repeat (3) @(negedge clk);

    // rejected stores
    for (int i = 0; i < 3; i++) begin
      set_store(bad_src[i], bad_addr[i], 32'hDEAD0000 + 32'(i));
      @(negedge clk);
      StoreValidM = 1'b0;
      chk("t3_fault_hi", 32'(StoreFaultM), 32'h1);
      chk("t3_empty", 32'(BufEmpty), 32'h1);
      @(negedge clk);
      chk("t3_fault_lo", 32'(StoreFaultM), 32'h0);
      chk("t3_empty2", 32'(BufEmpty), 32'h1);
    end

    // fill with no acks, attempt a fifth, then drain
    MemAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_store(2'b00, 32'h4000 + 32'(4 * i), 32'h11110000 + 32'(i));
      @(negedge clk);
    end
    set_store(2'b00, 32'h4100, 32'h55555555);
    @(negedge clk);
    StoreValidM = 1'b0;
    chk("t4_full", 32'(StoreReadyM), 32'h0);
    chk("t4_head", MemAddr, 32'h4000);
    MemAck = 1'b1;
    @(negedge clk);
    chk("t4_ready_after_ack", 32'(StoreReadyM), 32'h1);
    chk("t4_second", MemAddr, 32'h4004);
    chk("t4_second_data", MemWData, 32'h11110001);
    repeat (3) @(negedge clk);
    chk("t4_drained", 32'(BufEmpty), 32'h1);
    chk("t4_count", 32'(drained), 32'(accepted));

    // continuous push with continuous ack, wraps pointers several times
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0:       set_store(2'b01, 32'h5000 + 32'(4 * i) + 32'(i % 4), 32'hA0000000 + 32'(i) * 32'h01010101);
        1:       set_store(2'b10, 32'h5002 + 32'(4 * i), 32'hB0000000 + 32'(i) * 32'h01010101);
        default: set_store(2'b00, 32'h5000 + 32'(4 * i), 32'hC0000000 + 32'(i) * 32'h01010101);
      endcase
      @(negedge clk);
    end
    StoreValidM = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_empty", 32'(BufEmpty), 32'h1);
    chk("t5_no_loss", 32'(drained), 32'(accepted));

    // reset while a request is outstanding
    MemAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_store(2'b00, 32'h6000 + 32'(4 * i), 32'h66000000 + 32'(i));
      @(negedge clk);
    end
    StoreValidM = 1'b0;
    @(negedge clk);
    chk("t6_req_before", 32'(MemReq), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(MemReq), 32'h0);
    chk("t6_rst_addr", MemAddr, 32'h0);
    chk("t6_rst_wdata", MemWData, 32'h0);
    chk("t6_rst_be", 32'(MemByteEn), 32'h0);
    chk("t6_rst_empty", 32'(BufEmpty), 32'h1);
    chk("t6_rst_ready", 32'(StoreReadyM), 32'h1);
    @(negedge clk);
    rst_n  = 1'b1;
    MemAck = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_discarded", 32'(BufEmpty), 32'h1);
    chk("t6_no_req", 32'(MemReq), 32'h0);

`ifdef STORE_BUF_FWD_EN
    MemAck = 1'b0;
    set_store(2'b01, 32'h1003, 32'h000000A5);
    @(negedge clk);
    StoreValidM = 1'b0;
    LoadValidM  = 1'b1;
    LoadAddrM   = 32'h1000;
    #1 chk("fwd_hit", 32'(LoadHazardM), 32'h1);
    LoadAddrM   = 32'h1004;
    #1 chk("fwd_miss", 32'(LoadHazardM), 32'h0);
    @(negedge clk);
    LoadAddrM   = 32'h1002;
    #1 chk("fwd_hit_inflight", 32'(LoadHazardM), 32'h1);
    LoadValidM  = 1'b0;
    #1 chk("fwd_no_valid", 32'(LoadHazardM), 32'h0);
    MemAck = 1'b1;
    repeat (3) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
